// File: rtl/lamp_bank_pkg.sv
// Shared register map and sizing helpers for the lamp bank controller.
package lamp_bank_pkg;

    localparam int ADDR_CTRL         = 0;
    localparam int ADDR_DUTY         = 1;
    localparam int ADDR_BLINK_PERIOD = 2;
    localparam int ADDR_STATUS       = 3;
    localparam int ADDR_STATE_BASE   = 4;

    localparam int BLINK_PERIOD_W    = 24;

    // Number of 32-bit register words needed to hold one bit per lamp.
    function automatic int words_for(input int num_lamps);
        return (num_lamps + 31) / 32;
    endfunction

endpackage

// File: rtl/lamp_pwm_blink_gen.sv
// Timing generator: blink prescaler, blink half-period counter with phase,
// and the free-running PWM comparator shared by all lamps.
import lamp_bank_pkg::*;

module lamp_pwm_blink_gen #(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 50000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PWM_BITS-1:0]       duty,
    input  logic [BLINK_PERIOD_W-1:0] blink_period,
    input  logic                      restart,
    output logic                      blink_phase,
    output logic                      pwm_on
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]           presc;
    logic                      tick;
    logic [BLINK_PERIOD_W-1:0] blink_cnt;
    logic [PWM_BITS-1:0]       pwm_cnt;

    assign tick = (presc == PS_LAST);

    // Prescaler: wraps every PRESCALE clocks; a restart pulls it back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (restart || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PS_W'(1);
        end
    end

    // Blink counter and phase; restart wins over a coincident tick or toggle,
    // and a zero period parks the phase high so blinking lamps stay lit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (restart || (blink_period == '0)) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (tick) begin
            if (blink_cnt == (blink_period - BLINK_PERIOD_W'(1))) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt   <= blink_cnt + BLINK_PERIOD_W'(1);
            end
        end
    end

    // Free-running PWM counter, never disturbed by restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // All-ones duty means fully on rather than one clock dark per period.
    assign pwm_on = (pwm_cnt < duty) || (duty == '1);

endmodule

// File: rtl/lamp_bank_ctrl.sv
// Avalon-MM lamp bank: register file, bus decode, lamp combine and the
// registered lamp outputs exported from the SoC.
import lamp_bank_pkg::*;

module lamp_bank_ctrl #(
    parameter int NUM_LAMPS = 42,
    parameter int PWM_BITS  = 8,
    parameter int PRESCALE  = 50000,
    parameter int ADDR_W    = 4
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic [ADDR_W-1:0]    avs_address,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    input  logic                 avs_read,
    output logic [31:0]          avs_readdata,
    output logic [NUM_LAMPS-1:0] lamps_export
);

    localparam int WORDS          = words_for(NUM_LAMPS);
    localparam int ADDR_MASK_BASE = ADDR_STATE_BASE + WORDS;

    logic [31:0]               addr;
    logic                      wr_ctrl;
    logic                      wr_duty;
    logic                      wr_period;
    logic                      restart;

    logic                      enable;
    logic [PWM_BITS-1:0]       duty;
    logic [BLINK_PERIOD_W-1:0] blink_period;
    logic [NUM_LAMPS-1:0]      lamp_state;
    logic [NUM_LAMPS-1:0]      lamp_mask;

    logic                      blink_phase;
    logic                      pwm_on;
    logic [31:0]               rd_data;
    logic [NUM_LAMPS-1:0]      lit;

    assign addr      = 32'(avs_address);
    assign wr_ctrl   = avs_write && (addr == ADDR_CTRL);
    assign wr_duty   = avs_write && (addr == ADDR_DUTY);
    assign wr_period = avs_write && (addr == ADDR_BLINK_PERIOD);
    assign restart   = (wr_ctrl && avs_writedata[1]) || wr_period;

    lamp_pwm_blink_gen #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_gen (
        .clk          (clk_clk),
        .rst          (reset_reset),
        .duty         (duty),
        .blink_period (blink_period),
        .restart      (restart),
        .blink_phase  (blink_phase),
        .pwm_on       (pwm_on)
    );

    // Register file writes; lamp bits beyond NUM_LAMPS simply have no storage.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            enable       <= 1'b0;
            duty         <= '1;
            blink_period <= '0;
            lamp_state   <= '0;
            lamp_mask    <= '0;
        end else begin
            if (wr_ctrl) begin
                enable <= avs_writedata[0];
            end
            if (wr_duty) begin
                duty <= avs_writedata[PWM_BITS-1:0];
            end
            if (wr_period) begin
                blink_period <= avs_writedata[BLINK_PERIOD_W-1:0];
            end
            for (int i = 0; i < NUM_LAMPS; i++) begin
                if (avs_write && (addr == ADDR_STATE_BASE + i / 32)) begin
                    lamp_state[i] <= avs_writedata[i % 32];
                end
                if (avs_write && (addr == ADDR_MASK_BASE + i / 32)) begin
                    lamp_mask[i] <= avs_writedata[i % 32];
                end
            end
        end
    end

    // Read mux; unmapped addresses and unimplemented bits return zero.
    always_comb begin
        rd_data = '0;
        if (addr == ADDR_CTRL) begin
            rd_data[0] = enable;
        end else if (addr == ADDR_DUTY) begin
            rd_data[PWM_BITS-1:0] = duty;
        end else if (addr == ADDR_BLINK_PERIOD) begin
            rd_data[BLINK_PERIOD_W-1:0] = blink_period;
        end else if (addr == ADDR_STATUS) begin
            rd_data[1:0] = {enable, blink_phase};
        end
        for (int i = 0; i < NUM_LAMPS; i++) begin
            if (addr == ADDR_STATE_BASE + i / 32) begin
                rd_data[i % 32] = lamp_state[i];
            end
            if (addr == ADDR_MASK_BASE + i / 32) begin
                rd_data[i % 32] = lamp_mask[i];
            end
        end
    end

    // Read data register: captures pre-write contents and holds until next read.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_data;
        end
    end

    assign lit = {NUM_LAMPS{enable & pwm_on}} & lamp_state
               & (~lamp_mask | {NUM_LAMPS{blink_phase}});

    // Registered lamp drive.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            lamps_export <= '0;
        end else begin
            lamps_export <= lit;
        end
    end

endmodule

// File: tb/tb_lamp_bank_ctrl.sv
// Scenario-driven bench for lamp_bank_ctrl with a short blink prescale.
module tb_lamp_bank_ctrl;

    localparam int NUM_LAMPS = 42;
    localparam int PWM_BITS  = 8;
    localparam int PRESCALE  = 4;
    localparam int ADDR_W    = 4;

    logic                 clk_clk;
    logic                 reset_reset;
    logic [ADDR_W-1:0]    avs_address;
    logic                 avs_write;
    logic [31:0]          avs_writedata;
    logic                 avs_read;
    logic [31:0]          avs_readdata;
    logic [NUM_LAMPS-1:0] lamps_export;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0]          rd_q[$];
    logic [NUM_LAMPS-1:0] lamp_q[$];
    int                   cnt_q[$];

    lamp_bank_ctrl #(
        .NUM_LAMPS (NUM_LAMPS),
        .PWM_BITS  (PWM_BITS),
        .PRESCALE  (PRESCALE),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset   (reset_reset),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .lamps_export  (lamps_export)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk_clk);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(posedge clk_clk);
        #1;
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk_clk);
        avs_address = a;
        avs_read    = 1'b1;
        @(posedge clk_clk);
        #1;
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic test_reset();
        logic [3:0]  addrs [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        logic [31:0] exps  [8] = '{32'h0, 32'hFF, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
        logic [31:0] got;
        logic [31:0] exp;
        @(negedge clk_clk);
        vectors++;
        if (lamps_export !== '0 || avs_readdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: lamps=%h readdata=%h, expected 0/0", lamps_export, avs_readdata);
        end
        for (int i = 0; i < 8; i++) begin
            rd_q.push_back(exps[i]);
            bus_read(addrs[i], got);
            exp = rd_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_read addr %0d: got %h, expected %h", addrs[i], got, exp);
            end
        end
    endtask

    task automatic test_static();
        logic [31:0] got;
        logic [31:0] exp;
        logic [NUM_LAMPS-1:0] lexp;
        bus_write(4'd0, 32'h1);
        bus_write(4'd4, 32'h0000_00A5);
        bus_write(4'd5, 32'h0000_03FF);
        lamp_q.push_back(42'h000_0000_00A5);
        lamp_q.push_back(42'h3FF_0000_00A5);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_clk);
            lexp = lamp_q.pop_front();
            vectors++;
            if (lamps_export !== lexp) begin
                miscompares++;
                $display("FAIL static_lamps edge+%0d: got %h, expected %h", i, lamps_export, lexp);
            end
        end
        bus_write(4'd5, 32'hFFFF_FFFF);
        bus_write(4'd7, 32'hFFFF_FFFF);
        rd_q.push_back(32'h0000_03FF);
        rd_q.push_back(32'h0000_00A5);
        rd_q.push_back(32'h0000_03FF);
        bus_read(4'd5, got);
        exp = rd_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL state_word1_clip: got %h, expected %h", got, exp);
        end
        bus_read(4'd4, got);
        exp = rd_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL state_word0: got %h, expected %h", got, exp);
        end
        bus_read(4'd7, got);
        exp = rd_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL mask_word1_clip: got %h, expected %h", got, exp);
        end
        bus_write(4'd7, 32'h0);
        // Disable blanks outputs but keeps the lamp state.
        bus_write(4'd0, 32'h0);
        @(negedge clk_clk);
        @(negedge clk_clk);
        vectors++;
        if (lamps_export !== '0) begin
            miscompares++;
            $display("FAIL disable_blank: got %h, expected 0", lamps_export);
        end
        rd_q.push_back(32'h0000_00A5);
        bus_read(4'd4, got);
        exp = rd_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL disable_keeps_state: got %h, expected %h", got, exp);
        end
        bus_write(4'd0, 32'h1);
    endtask

    task automatic test_pwm();
        int duties [4] = '{64, 0, 255, 1};
        int hi;
        int exp;
        bus_write(4'd4, 32'h1);
        bus_write(4'd5, 32'h0);
        for (int d = 0; d < 4; d++) begin
            bus_write(4'd1, 32'(duties[d]));
            cnt_q.push_back((duties[d] == 255) ? 256 : duties[d]);
            @(negedge clk_clk);
            @(negedge clk_clk);
            hi = 0;
            for (int c = 0; c < 256; c++) begin
                @(negedge clk_clk);
                if (lamps_export[0] === 1'b1) hi++;
            end
            exp = cnt_q.pop_front();
            vectors++;
            if (hi != exp) begin
                miscompares++;
                $display("FAIL pwm_duty_%0d: high %0d of 256 clocks, expected %0d", duties[d], hi, exp);
            end
        end
        bus_write(4'd1, 32'hFF);
    endtask

    task automatic test_blink();
        logic [NUM_LAMPS-1:0] lexp;
        logic [31:0] got;
        logic [31:0] exp;
        bus_write(4'd4, 32'h3);
        bus_write(4'd6, 32'h1);
        bus_write(4'd2, 32'd3);
        for (int j = 0; j <= 48; j++) begin
            @(negedge clk_clk);
            if (j >= 1) begin
                lamp_q.push_back({40'b0, 1'b1, (((j - 1) / 12) % 2 == 0)});
                lexp = lamp_q.pop_front();
                vectors++;
                if (lamps_export !== lexp) begin
                    miscompares++;
                    $display("FAIL blink cycle %0d: got %h, expected %h", j, lamps_export, lexp);
                end
            end
        end
        bus_write(4'd2, 32'd0);
        for (int j = 0; j <= 30; j++) begin
            @(negedge clk_clk);
            if (j >= 1) begin
                lamp_q.push_back(42'h3);
                lexp = lamp_q.pop_front();
                vectors++;
                if (lamps_export !== lexp) begin
                    miscompares++;
                    $display("FAIL blink_period0 cycle %0d: got %h, expected %h", j, lamps_export, lexp);
                end
            end
        end
        rd_q.push_back(32'h3);
        bus_read(4'd3, got);
        exp = rd_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL status_period0: got %h, expected %h", got, exp);
        end
    endtask

    task automatic test_restart_collision();
        logic [NUM_LAMPS-1:0] lexp;
        bus_write(4'd2, 32'd3);
        // Second write lands on the edge where the first toggle is due.
        repeat (11) @(posedge clk_clk);
        bus_write(4'd2, 32'd3);
        for (int j = 0; j <= 36; j++) begin
            @(negedge clk_clk);
            if (j >= 1) begin
                lamp_q.push_back({40'b0, 1'b1, (((j - 1) / 12) % 2 == 0)});
                lexp = lamp_q.pop_front();
                vectors++;
                if (lamps_export !== lexp) begin
                    miscompares++;
                    $display("FAIL restart_collision cycle %0d: got %h, expected %h", j, lamps_export, lexp);
                end
            end
        end
    endtask

    task automatic test_bus_edges();
        logic [31:0] got;
        logic [31:0] exp;
        bus_write(4'hE, 32'hFFFF_FFFF);
        bus_write(4'h8, 32'hFFFF_FFFF);
        rd_q.push_back(32'h0);
        bus_read(4'hF, got);
        exp = rd_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL unmapped_read: got %h, expected %h", got, exp);
        end
        rd_q.push_back(32'h0);
        bus_read(4'hE, got);
        exp = rd_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL unmapped_write_ignored: got %h, expected %h", got, exp);
        end
        rd_q.push_back(32'h3);
        bus_read(4'd4, got);
        exp = rd_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL state_after_unmapped: got %h, expected %h", got, exp);
        end
        bus_write(4'd0, 32'h3);
        rd_q.push_back(32'h1);
        bus_read(4'd0, got);
        exp = rd_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL ctrl_restart_selfclear: got %h, expected %h", got, exp);
        end
        // Simultaneous read and write of DUTY.
        rd_q.push_back(32'hFF);
        rd_q.push_back(32'h40);
        @(negedge clk_clk);
        avs_address   = 4'd1;
        avs_writedata = 32'h40;
        avs_write     = 1'b1;
        avs_read      = 1'b1;
        @(posedge clk_clk);
        #1;
        avs_write = 1'b0;
        avs_read  = 1'b0;
        got = avs_readdata;
        exp = rd_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL rw_same_cycle_old: got %h, expected %h", got, exp);
        end
        bus_read(4'd1, got);
        exp = rd_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL rw_same_cycle_new: got %h, expected %h", got, exp);
        end
    endtask

    task automatic test_reset_midrun();
        logic [3:0]  addrs [4] = '{4'd1, 4'd3, 4'd4, 4'd0};
        logic [31:0] exps  [4] = '{32'hFF, 32'h1, 32'h0, 32'h0};
        logic [31:0] got;
        logic [31:0] exp;
        bus_write(4'd1, 32'hFF);
        @(negedge clk_clk);
        @(negedge clk_clk);
        vectors++;
        if (lamps_export !== 42'h3) begin
            miscompares++;
            $display("FAIL pre_reset_lamps: got %h, expected %h", lamps_export, 42'h3);
        end
        @(posedge clk_clk);
        #2;
        reset_reset = 1'b1;
        #1;
        vectors++;
        if (lamps_export !== '0 || avs_readdata !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset: lamps=%h readdata=%h, expected 0/0", lamps_export, avs_readdata);
        end
        repeat (2) @(negedge clk_clk);
        reset_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_q.push_back(exps[i]);
            bus_read(addrs[i], got);
            exp = rd_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL midrun_reset_read addr %0d: got %h, expected %h", addrs[i], got, exp);
            end
        end
        @(negedge clk_clk);
        vectors++;
        if (lamps_export !== '0) begin
            miscompares++;
            $display("FAIL post_reset_lamps: got %h, expected 0", lamps_export);
        end
    endtask

    initial begin
        reset_reset   = 1'b1;
        avs_address   = '0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        avs_read      = 1'b0;
        repeat (3) @(posedge clk_clk);
        #1;
        reset_reset = 1'b0;

        test_reset();
        test_static();
        test_pwm();
        test_blink();
        test_restart_collision();
        test_bus_edges();
        test_reset_midrun();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
